// File: rtl/vga_frame_scanout.sv
// 160x120 3-bit frame store with a pixel-plot write port, scanned out as 640x480@60 Hz VGA
// with 4x4 pixel replication and a start-of-vertical-blank pulse for redraw timing.
module vga_frame_scanout #(
   parameter int H_FRONT = 16,
   parameter int H_SYNC  = 96,
   parameter int H_BACK  = 48,
   parameter int V_FRONT = 10,
   parameter int V_SYNC  = 2,
   parameter int V_BACK  = 33
)(
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] x,
   input  logic [6:0] y,
   input  logic [2:0] colour,
   input  logic       plot,
   output logic       vblank_start,
   output logic       VGA_CLK,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_BLANK,
   output logic       VGA_SYNC,
   output logic [9:0] VGA_R,
   output logic [9:0] VGA_G,
   output logic [9:0] VGA_B
);

   localparam int H_VIS     = 640;
   localparam int V_VIS     = 480;
   localparam int H_TOTAL   = H_VIS + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL   = V_VIS + V_FRONT + V_SYNC + V_BACK;
   localparam int MEM_WORDS = 160 * 120;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FRONT);
   localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FRONT);
   localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FRONT + V_SYNC - 1);

   logic        r_pixEn;
   logic        r_vgaClk;
   logic [9:0]  r_hCount;
   logic [9:0]  r_vCount;
   logic [14:0] r_rdAddr;
   logic [2:0]  r_rdData;
   logic        r_hs1;
   logic        r_vs1;
   logic        r_vis1;
   logic        r_vb1;
   logic        r_hs;
   logic        r_vs;
   logic        r_blank;
   logic        r_vblank;
   logic [2:0]  r_rgb;
   logic [2:0]  r_mem [MEM_WORDS];

   logic [14:0] w_wrAddr;
   logic [14:0] w_rdAddr;
   logic        w_wrEn;
   logic        w_visible;
   logic        w_hsN;
   logic        w_vsN;
   logic        w_vbHit;

   // y*160 is built from shifts so no multiplier is needed on either port.
   assign w_wrAddr  = ({8'd0, y} << 7) + ({8'd0, y} << 5) + {7'd0, x};
   assign w_wrEn    = plot && (x < 8'd160) && (y < 7'd120);
   assign w_rdAddr  = ({7'd0, r_vCount[9:2]} << 7) + ({7'd0, r_vCount[9:2]} << 5)
                    + {7'd0, r_hCount[9:2]};
   assign w_visible = (r_hCount < 10'(H_VIS)) && (r_vCount < 10'(V_VIS));
   assign w_hsN     = !((r_hCount >= HS_FIRST) && (r_hCount <= HS_LAST));
   assign w_vsN     = !((r_vCount >= VS_FIRST) && (r_vCount <= VS_LAST));
   assign w_vbHit   = (r_hCount == 10'd0) && (r_vCount == 10'(V_VIS));

   // Read-before-write on a shared address; the frame store has no reset.
   always_ff @(posedge clock) begin
      if (w_wrEn) r_mem[w_wrAddr] <= colour;
      r_rdData <= (r_rdAddr < 15'(MEM_WORDS)) ? r_mem[r_rdAddr] : 3'b000;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_pixEn  <= 1'b0;
         r_vgaClk <= 1'b0;
         r_hCount <= '0;
         r_vCount <= '0;
         r_rdAddr <= '0;
         r_hs1    <= 1'b1;
         r_vs1    <= 1'b1;
         r_vis1   <= 1'b0;
         r_vb1    <= 1'b0;
         r_hs     <= 1'b1;
         r_vs     <= 1'b1;
         r_blank  <= 1'b0;
         r_vblank <= 1'b0;
         r_rgb    <= 3'b000;
      end else begin
         r_pixEn  <= ~r_pixEn;
         r_vgaClk <= r_pixEn;
         r_vblank <= 1'b0;
         if (r_pixEn) begin
            if (r_hCount == H_LAST) begin
               r_hCount <= '0;
               r_vCount <= (r_vCount == V_LAST) ? 10'd0 : r_vCount + 10'd1;
            end else begin
               r_hCount <= r_hCount + 10'd1;
            end
            // Syncs and the vblank marker ride the same two-tick pipe as the colour data.
            r_rdAddr <= w_rdAddr;
            r_hs1    <= w_hsN;
            r_vs1    <= w_vsN;
            r_vis1   <= w_visible;
            r_vb1    <= w_vbHit;
            r_hs     <= r_hs1;
            r_vs     <= r_vs1;
            r_blank  <= r_vis1;
            r_rgb    <= r_vis1 ? r_rdData : 3'b000;
            r_vblank <= r_vb1;
         end
      end
   end

   assign vblank_start = r_vblank;
   assign VGA_CLK      = r_vgaClk;
   assign VGA_HS       = r_hs;
   assign VGA_VS       = r_vs;
   assign VGA_BLANK    = r_blank;
   assign VGA_SYNC     = 1'b0;
   assign VGA_R        = {10{r_rgb[2]}};
   assign VGA_G        = {10{r_rgb[1]}};
   assign VGA_B        = {10{r_rgb[0]}};

endmodule

// File: tb/tb_vga_frame_scanout.sv
// Bench for vga_frame_scanout: a pixel-timeline model of the frame store and raster
// predicts every output pin on every clock, plus targeted counts for the scenarios.
module tb_vga_frame_scanout;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot;
   logic       vblank_start, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC;
   logic [9:0] VGA_R, VGA_G, VGA_B;

   vga_frame_scanout dut (
      .clock(clock), .reset(reset), .x(x), .y(y), .colour(colour), .plot(plot),
      .vblank_start(vblank_start), .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
      .VGA_BLANK(VGA_BLANK), .VGA_SYNC(VGA_SYNC), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
   );

   always #10 clock = ~clock;

   localparam int LINE      = 1600;
   localparam int FRAME_PIX = 420000;
   localparam logic [35:0] RESET_VEC = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 30'd0};

   int          checks = 0;
   int          failures = 0;
   int unsigned n = 0;
   logic [2:0]  modelMem [19200];
   logic [2:0]  readColour = 3'b000;
   logic [2:0]  dispColour = 3'b000;
   logic [35:0] expVec;
   bit          dispValid;
   int          dispH, dispV, cntH;

   function automatic logic [35:0] obs();
      return {VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, vblank_start, VGA_R, VGA_G, VGA_B};
   endfunction

   function automatic logic [9:0] chan(input logic b);
      return b ? 10'h3FF : 10'h000;
   endfunction

   // n counts clock edges since reset release. Pixel P is fetched on edge 2P+3 and
   // shown at the pins from edge 2P+4, so syncs and colour are pure functions of n.
   task automatic tick();
      int   p, hh, vv;
      logic vis;
      @(posedge clock);
      if (reset) n = 0; else n++;
      if (n >= 4 && n % 2 == 0) dispColour = readColour;
      if (n >= 3 && n % 2 == 1) begin
         p  = int'((n - 3) / 2) % FRAME_PIX;
         hh = p % 800;
         vv = p / 800;
         readColour = (hh < 640 && vv < 480) ? modelMem[(vv / 4) * 160 + hh / 4] : 3'b000;
      end
      if (plot && x < 8'd160 && y < 7'd120) modelMem[int'(y) * 160 + int'(x)] = colour;
      cntH = int'(n / 2) % 800;
      #1;
      if (n < 4) begin
         expVec     = RESET_VEC;
         expVec[35] = (n >= 2 && n % 2 == 0);
         dispValid  = 1'b0;
         dispH      = -1;
         dispV      = -1;
      end else begin
         p         = int'((n - 4) / 2) % FRAME_PIX;
         dispH     = p % 800;
         dispV     = p / 800;
         dispValid = 1'b1;
         vis       = (dispH < 640 && dispV < 480);
         expVec    = {(n % 2 == 0), !(dispH >= 656 && dispH <= 751), !(dispV >= 490 && dispV <= 491),
                      vis, 1'b0, ((n - 4) % 840000 == 768000),
                      chan(vis & dispColour[2]), chan(vis & dispColour[1]), chan(vis & dispColour[0])};
      end
   endtask

   task automatic test_reset();
      int errs = 0;
      reset = 1'b1; plot = 1'b0; x = '0; y = '0; colour = '0;
      for (int i = 0; i < 19200; i++) modelMem[i] = 3'b000;
      #1;
      checks++;
      if (obs() !== RESET_VEC) begin
         failures++;
         $display("[TB] FAIL reset_values: got=%h required=%h", obs(), RESET_VEC);
      end
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < 160; c++) begin
            x = 8'(c); y = 7'(r); colour = 3'b000; plot = 1'b1;
            tick();
            if (obs() !== expVec) errs++;
         end
      end
      plot = 1'b0;
      checks++;
      if (errs != 0) begin
         failures++;
         $display("[TB] FAIL reset_hold: bad samples=%0d required=0", errs);
      end
   endtask

   task automatic test_sync_timing();
      int   errs = 0, hsLow = 0, fall1 = -1, fall2 = -1, rgbOn = 0;
      logic prevHs = 1'b1;
      reset = 1'b0;
      for (int i = 0; i < 3 * LINE; i++) begin
         tick();
         if (obs() !== expVec) errs++;
         if (dispValid && dispV == 1 && VGA_HS === 1'b0) hsLow++;
         if (prevHs === 1'b1 && VGA_HS === 1'b0) begin
            if (fall1 < 0) fall1 = int'(n);
            else if (fall2 < 0) fall2 = int'(n);
         end
         prevHs = VGA_HS;
         if ({VGA_R, VGA_G, VGA_B} !== 30'd0) rgbOn++;
      end
      checks++;
      if (errs != 0) begin failures++; $display("[TB] FAIL sync_model: bad samples=%0d required=0", errs); end
      checks++;
      if (hsLow != 192) begin failures++; $display("[TB] FAIL hs_low_width: got=%0d required=192", hsLow); end
      checks++;
      if (fall2 - fall1 != LINE) begin
         failures++;
         $display("[TB] FAIL hs_period: got=%0d required=%0d", fall2 - fall1, LINE);
      end
      checks++;
      if (rgbOn != 0) begin failures++; $display("[TB] FAIL sync_rgb_zero: got=%0d required=0", rgbOn); end
   endtask

   task automatic test_bounds();
      int         errs = 0, gbHit = 0, leak = 0;
      logic [7:0] bx [5];
      logic [6:0] by [5];
      logic [2:0] bc [5];
      bx = '{8'd160, 8'd0, 8'd200, 8'd159, 8'd159};
      by = '{7'd0, 7'd120, 7'd127, 7'd1, 7'd119};
      bc = '{3'b111, 3'b111, 3'b111, 3'b011, 3'b011};
      for (int i = 0; i < 5; i++) begin
         x = bx[i]; y = by[i]; colour = bc[i]; plot = 1'b1;
         tick();
         if (obs() !== expVec) errs++;
      end
      plot = 1'b0;
      while (n < 8 * LINE + 4) begin
         tick();
         if (obs() !== expVec) errs++;
         if (dispValid && dispV >= 4 && dispV <= 7) begin
            if (dispH >= 636 && dispH <= 639 && VGA_G === 10'h3FF && VGA_B === 10'h3FF && VGA_R === 10'h0)
               gbHit++;
            if (dispH < 4 && {VGA_R, VGA_G, VGA_B} !== 30'd0) leak++;
         end
      end
      checks++;
      if (errs != 0) begin failures++; $display("[TB] FAIL bounds_model: bad samples=%0d required=0", errs); end
      checks++;
      if (gbHit != 32) begin failures++; $display("[TB] FAIL bounds_edge_pixel: got=%0d required=32", gbHit); end
      checks++;
      if (leak != 0) begin failures++; $display("[TB] FAIL bounds_dropped: got=%0d required=0", leak); end
   endtask

   task automatic test_single_write();
      int errs = 0, inR = 0, outR = 0, gb = 0;
      x = 8'd5; y = 7'd3; colour = 3'b100; plot = 1'b1;
      tick();
      if (obs() !== expVec) errs++;
      plot = 1'b0;
      while (n < 17 * LINE + 4) begin
         tick();
         if (obs() !== expVec) errs++;
         if (VGA_R === 10'h3FF) begin
            if (dispH >= 20 && dispH <= 23 && dispV >= 12 && dispV <= 15) inR++;
            else outR++;
         end
         if ({VGA_G, VGA_B} !== 20'd0) gb++;
      end
      checks++;
      if (errs != 0) begin failures++; $display("[TB] FAIL single_model: bad samples=%0d required=0", errs); end
      checks++;
      if (inR != 32) begin failures++; $display("[TB] FAIL single_red_block: got=%0d required=32", inR); end
      checks++;
      if (outR != 0 || gb != 0) begin
         failures++;
         $display("[TB] FAIL single_elsewhere: red=%0d gb=%0d required=0/0", outR, gb);
      end
   endtask

   task automatic test_blanking();
      int errs = 0, bad = 0;
      while (n < 19 * LINE + 4) begin
         if (cntH >= 640) begin
            x = 8'($urandom_range(0, 159)); y = 7'($urandom_range(6, 10)); colour = 3'b111; plot = 1'b1;
         end else begin
            plot = 1'b0;
         end
         tick();
         if (obs() !== expVec) errs++;
         if (dispValid && dispH >= 640 && (VGA_BLANK !== 1'b0 || {VGA_R, VGA_G, VGA_B} !== 30'd0)) bad++;
      end
      plot = 1'b0;
      checks++;
      if (errs != 0) begin failures++; $display("[TB] FAIL blank_model: bad samples=%0d required=0", errs); end
      checks++;
      if (bad != 0) begin failures++; $display("[TB] FAIL blank_dark: got=%0d required=0", bad); end
   endtask

   task automatic test_reset_midframe();
      int errs = 0;
      while (cntH < 300) begin
         tick();
         if (obs() !== expVec) errs++;
      end
      reset = 1'b1;
      #1;
      checks++;
      if (obs() !== RESET_VEC) begin
         failures++;
         $display("[TB] FAIL reset_immediate: got=%h required=%h", obs(), RESET_VEC);
      end
      repeat (3) begin
         tick();
         if (obs() !== expVec) errs++;
      end
      reset = 1'b0;
      repeat (2) begin
         tick();
         if (obs() !== expVec) errs++;
      end
      checks++;
      if (errs != 0) begin failures++; $display("[TB] FAIL midreset_model: bad samples=%0d required=0", errs); end
   endtask

   task automatic test_collision();
      int errs = 0, firstBlank = -1, b0 = 0, b1 = 0, keep = 0;
      x = 8'd0; y = 7'd0; colour = 3'b001; plot = 1'b1;
      tick();
      if (obs() !== expVec) errs++;
      plot = 1'b0;
      while (n < 8 * LINE + 4) begin
         tick();
         if (obs() !== expVec) errs++;
         if (firstBlank < 0 && VGA_BLANK === 1'b1) firstBlank = int'(n);
         if (dispV == 0 && dispH == 0 && VGA_B !== 10'h0) b0++;
         if (dispV == 1 && dispH >= 0 && dispH < 4 && VGA_B === 10'h3FF) b1++;
         if (dispV >= 4 && dispV <= 7 && dispH >= 636 && dispH <= 639 && VGA_G === 10'h3FF && VGA_B === 10'h3FF)
            keep++;
      end
      checks++;
      if (errs != 0) begin failures++; $display("[TB] FAIL collide_model: bad samples=%0d required=0", errs); end
      checks++;
      if (firstBlank != 4) begin failures++; $display("[TB] FAIL restart_edge: got=%0d required=4", firstBlank); end
      checks++;
      if (b0 != 0) begin failures++; $display("[TB] FAIL collide_old_value: got=%0d required=0", b0); end
      checks++;
      if (b1 != 8) begin failures++; $display("[TB] FAIL collide_new_value: got=%0d required=8", b1); end
      checks++;
      if (keep != 32) begin failures++; $display("[TB] FAIL memory_preserved: got=%0d required=32", keep); end
   endtask

   task automatic test_random();
      int errs = 0;
      while (n < 16 * LINE + 4) begin
         if ($urandom_range(0, 2) == 0) begin
            x      = 8'($urandom_range(0, 169));
            y      = ($urandom_range(0, 7) == 0) ? 7'($urandom_range(118, 127)) : 7'($urandom_range(0, 5));
            colour = 3'($urandom);
            plot   = 1'b1;
         end else begin
            plot = 1'b0;
         end
         tick();
         if (obs() !== expVec) errs++;
      end
      plot = 1'b0;
      checks++;
      if (errs != 0) begin failures++; $display("[TB] FAIL random_model: bad samples=%0d required=0", errs); end
   endtask

   initial begin
      test_reset();
      test_sync_timing();
      test_bounds();
      test_single_write();
      test_blanking();
      test_reset_midframe();
      test_collision();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
